// File: rtl/loop_nest_sequencer.sv
// Nested-loop index sequencer: walks N index counters in odometer order up to
// per-level inclusive bounds, presenting one index tuple per valid/ready beat.
//
// state | meaning
// IDLE  | waiting for a configuration; cfg_ready high (outside reset)
// RUN   | presenting index beats; advances on m_valid && m_ready
module loop_nest_sequencer #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [N*W-1:0] cfg_max,
    input  logic           abort,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N*W-1:0] m_idx,
    output logic [N-1:0]   m_last,
    output logic           busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N*W-1:0] bound_q, bound_d;
    logic [N*W-1:0] idx_q, idx_d;
    logic [N-1:0]   eq;
    logic [N-1:0]   carry;

    // m_last[k] is the prefix AND of per-level "at bound" flags.
    always_comb begin
        logic acc;
        acc = 1'b1;
        eq  = '0;
        m_last = '0;
        for (int k = 0; k < N; k++) begin
            eq[k]     = (idx_q[k*W +: W] == bound_q[k*W +: W]);
            acc       = acc & eq[k];
            m_last[k] = acc;
        end
    end

    // Level k advances when every lower level is at its bound.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int k = 1; k < N; k++) begin
            carry[k] = m_last[k-1];
        end
    end

    assign cfg_ready = (state_q == S_IDLE) && rstn;
    assign m_valid   = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign m_idx     = idx_q;

    always_comb begin
        state_d = state_q;
        bound_d = bound_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    bound_d = cfg_max;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else if (m_ready) begin
                    if (m_last[N-1]) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            if (carry[k]) begin
                                if (eq[k]) begin
                                    idx_d[k*W +: W] = '0;
                                end else begin
                                    idx_d[k*W +: W] = idx_q[k*W +: W] + {{(W-1){1'b0}}, 1'b1};
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            bound_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bound_q <= bound_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Self-checking bench for loop_nest_sequencer (W=8, N=3): table of nest
// configurations checked beat by beat, plus abort and reset sequences.
module tb_loop_nest_sequencer;

    localparam int W = 8;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rstn;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [N*W-1:0] cfg_max;
    logic           abort;
    logic           m_valid;
    logic           m_ready;
    logic [N*W-1:0] m_idx;
    logic [N-1:0]   m_last;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    loop_nest_sequencer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_max   (cfg_max),
        .abort     (abort),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
        int         beats;
        int         pct;
        bit         hold;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left on a falling edge; the following run can chain directly.
    task automatic run_nest(input vec_t v);
        int hs;
        int stall;
        logic [23:0] eidx;
        logic [2:0]  elast;
        hs = 0;
        chk("cfg_ready_pre", 32'(cfg_ready), 32'd1);
        cfg_max   = {v.b2, v.b1, v.b0};
        cfg_valid = 1'b1;
        m_ready   = 1'b0;
        @(negedge clk);
        if (!v.hold) cfg_valid = 1'b0;
        for (int e2 = 0; e2 <= int'(v.b2); e2++) begin
            for (int e1 = 0; e1 <= int'(v.b1); e1++) begin
                for (int e0 = 0; e0 <= int'(v.b0); e0++) begin
                    eidx     = {8'(e2), 8'(e1), 8'(e0)};
                    elast[0] = (e0 == int'(v.b0));
                    elast[1] = elast[0] && (e1 == int'(v.b1));
                    elast[2] = elast[1] && (e2 == int'(v.b2));
                    stall = 0;
                    forever begin
                        chk("m_valid", 32'(m_valid), 32'd1);
                        chk("m_idx", 32'(m_idx), 32'(eidx));
                        chk("m_last", 32'(m_last), 32'(elast));
                        if (v.hold) cfg_max = 24'($urandom);
                        m_ready = (stall >= 20) || ($urandom_range(99) < v.pct);
                        if (m_ready && m_valid) hs++;
                        @(negedge clk);
                        if (m_ready) break;
                        stall++;
                    end
                end
            end
        end
        m_ready   = 1'b0;
        cfg_valid = 1'b0;
        chk("beat_count", 32'(hs), 32'(v.beats));
        chk("m_valid_end", 32'(m_valid), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("cfg_ready_end", 32'(cfg_ready), 32'd1);
    endtask

    task automatic consume(input int n);
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'd2, 8'd1, 8'd3,   24,  100, 1'b0};
        vecs[1] = '{8'd0, 8'd0, 8'd0,   1,   100, 1'b0};
        vecs[2] = '{8'd0, 8'd0, 8'd255, 256, 20,  1'b0};
        vecs[3] = '{8'd1, 8'd1, 8'd1,   8,   50,  1'b0};
        vecs[4] = '{8'd2, 8'd1, 8'd3,   24,  100, 1'b1};
        vecs[5] = '{8'd0, 8'd3, 8'd0,   4,   100, 1'b0};
        vecs[6] = '{8'd1, 8'd0, 8'd2,   6,   30,  1'b0};

        rstn = 1'b0; cfg_valid = 1'b0; cfg_max = '0; abort = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'b111);
        chk("rst_m_idx", 32'(m_idx), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Abort while idle must not block acceptance or change anything.
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_ready", 32'(cfg_ready), 32'd1);
        abort = 1'b0;

        for (int i = 0; i < 7; i++) run_nest(vecs[i]);

        // Abort coinciding with a handshake on beat 5.
        cfg_max = {8'd2, 8'd1, 8'd3}; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        consume(4);
        chk("abort_beat5_idx", 32'(m_idx), 32'h000100);
        chk("abort_beat5_valid", 32'(m_valid), 32'd1);
        abort = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; m_ready = 1'b0;
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        chk("abort_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("abort_m_idx", 32'(m_idx), 32'd0);
        run_nest('{8'd0, 8'd0, 8'd1, 2, 100, 1'b0});

        // One-cycle reset mid-nest.
        cfg_max = {8'd2, 8'd1, 8'd3}; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        consume(5);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'b111);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid_after", 32'(m_valid), 32'd0);
        run_nest('{8'd1, 8'd1, 8'd1, 8, 100, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
